// File: rtl/ecc_core.sv
// ecc_core: modular add, sub and multiply of WIDTH-bit operands over a runtime modulus.
// Defining ECC_CORE_SQR_EN routes opcode 010 (a*a mod p) through the multiplier; otherwise 010 is unsupported.
module ecc_core #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] prime,
  input  logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_result,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ECC_CORE_SQR_EN
  localparam bit SQR_EN = 1'b1;
`else
  localparam bit SQR_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SQR = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_p;
  logic [WIDTH-1:0] acc;
  logic [2:0]       op_sel;
  logic [CW-1:0]    cnt;

  logic             launch_sqr;
  logic             is_mul;
  logic             op_fin;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH+1:0] p_ext;
  logic [WIDTH+1:0] dbl;
  logic [WIDTH+1:0] red1;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH-1:0] calc_res;

  // Squaring reuses the multiplier by loading a into both operand registers.
  assign launch_sqr = SQR_EN && (alu_sel == OP_SQR);
  assign is_mul     = (op_sel == OP_MUL) || (SQR_EN && (op_sel == OP_SQR));
  assign op_fin     = !is_mul || (cnt == CW'(WIDTH - 1));

  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b};
    add_res = (sum >= {1'b0, op_p}) ? (sum[WIDTH-1:0] - op_p) : sum[WIDTH-1:0];

    // A set top bit of the WIDTH+1 difference is the borrow; adding p back wraps into range.
    diff    = {1'b0, op_a} - {1'b0, op_b};
    sub_res = diff[WIDTH] ? (diff[WIDTH-1:0] + op_p) : diff[WIDTH-1:0];

    // r = 2r + a_i*b stays below 3p for reduced inputs, so two subtractions suffice.
    p_ext    = {2'b00, op_p};
    dbl      = {1'b0, acc, 1'b0} + (op_a[WIDTH-1] ? {2'b00, op_b} : '0);
    red1     = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    mul_next = (red1 >= p_ext) ? (red1[WIDTH-1:0] - op_p) : red1[WIDTH-1:0];

    calc_res = '0;
    case (op_sel)
      OP_ADD:  calc_res = add_res;
      OP_SUB:  calc_res = sub_res;
      OP_MUL:  calc_res = mul_next;
      OP_SQR:  calc_res = SQR_EN ? mul_next : '0;
      default: calc_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)  state_n = CALC;
      CALC:    if (op_fin) state_n = DONE;
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_p       <= '0;
      op_sel     <= '0;
      acc        <= '0;
      cnt        <= '0;
      alu_result <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= launch_sqr ? a : b;
            op_p   <= prime;
            op_sel <= alu_sel;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (is_mul) begin
            acc  <= mul_next;
            op_a <= op_a << 1;
            cnt  <= cnt + CW'(1);
          end
          if (op_fin) begin
            alu_result <= calc_res;
          end
        end
        default: ;
      endcase
      done <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_ecc_core.sv
// Self-checking bench for ecc_core: directed vectors plus randomized ops against a wide-arithmetic model.
module tb_ecc_core;

  localparam int W   = 256;
  localparam int LIM = W + 20;

  logic         i_clk;
  logic         i_rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] prime;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_result;
  logic         done;

  int n_checks;
  int n_fail;

  ecc_core #(.WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .prime      (prime),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .done       (done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: modular arithmetic done directly with double-width integers.
  function automatic logic [W-1:0] model(input logic [2:0] sel, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb, input logic [W-1:0] mp);
    logic [2*W-1:0] xa, xb, xp, t;
    xa = {{W{1'b0}}, ma};
    xb = {{W{1'b0}}, mb};
    xp = {{W{1'b0}}, mp};
    case (sel)
      3'b000:  t = (xa + xb) % xp;
      3'b001:  t = (xa + xp - xb) % xp;
      3'b011:  t = (xa * xb) % xp;
`ifdef ECC_CORE_SQR_EN
      3'b010:  t = (xa * xa) % xp;
`endif
      default: t = '0;
    endcase
    return t[W-1:0];
  endfunction

  function automatic int model_lat(input logic [2:0] sel);
`ifdef ECC_CORE_SQR_EN
    if (sel == 3'b010) return W;
`endif
    return (sel == 3'b011) ? W : 1;
  endfunction

  // Called at a negedge; returns at the negedge where done is first seen, start still high.
  task automatic do_op(input logic [2:0] sel, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ip, input bit scramble, input int drop_at,
                       output logic [W-1:0] res, output int lat);
    start   = 1'b1;
    alu_sel = sel;
    a       = ia;
    b       = ib;
    prime   = ip;
    @(posedge i_clk);
    lat = 0;
    while (lat < LIM) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
      if (done) break;
      if (scramble) begin
        a       = rand_w();
        b       = rand_w();
        prime   = rand_w();
        alu_sel = 3'($urandom_range(0, 7));
      end
      if (drop_at != 0 && lat == drop_at) start = 1'b0;
    end
    res = alu_result;
  endtask

  task automatic release_start();
    start = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    start = 1'b0;
    a = '0; b = '0; prime = '0; alu_sel = '0;
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if (alu_result !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: result=%0h done=%b, required result=0 done=0", alu_result, done);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: done=%b, required 0", done);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] res;
    int lat;
    do_op(3'b011, W'(1009), W'(2003), W'(7919), 1'b0, 0, res, lat);
    n_checks++;
    if (res !== W'(16'h0692) || lat != W) begin
      n_fail++;
      $display("FAIL mul_1009_2003: result=%0h lat=%0d, required 692 lat=%0d", res, lat, W);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (done !== 1'b1 || alu_result !== W'(16'h0692)) begin
        n_fail++;
        $display("FAIL hold_while_start: done=%b result=%0h, required done=1 result=692", done, alu_result);
      end
    end
    release_start();
    n_checks++;
    if (done !== 1'b0 || alu_result !== W'(16'h0692)) begin
      n_fail++;
      $display("FAIL release: done=%b result=%0h, required done=0 result=692", done, alu_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W-1:0] te [4];
    logic [W-1:0] res;
    int lat;
    ta = '{W'(7001), W'(5003), W'(4003), W'(1901)};
    tb = '{W'(7907), W'(6007), W'(5009), W'(2503)};
    te = '{W'(16'h0C19), W'(16'h01A0), W'(16'h0077), W'(16'h1A93)};
    for (int i = 0; i < 4; i++) begin
      do_op(3'b011, ta[i], tb[i], W'(7919), 1'b0, 0, res, lat);
      n_checks++;
      if (res !== te[i] || lat != W) begin
        n_fail++;
        $display("FAIL b2b_%0d: result=%0h lat=%0d, required %0h lat=%0d", i, res, lat, te[i], W);
      end
      release_start();
    end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] res;
    int lat;
    do_op(3'b000, W'(5000), W'(4000), W'(7919), 1'b0, 0, res, lat);
    n_checks++;
    if (res !== W'(1081) || lat != 1) begin
      n_fail++;
      $display("FAIL add_5000_4000: result=%0d lat=%0d, required 1081 lat=1", res, lat);
    end
    release_start();
    do_op(3'b001, W'(1000), W'(2000), W'(7919), 1'b0, 0, res, lat);
    n_checks++;
    if (res !== W'(6919) || lat != 1) begin
      n_fail++;
      $display("FAIL sub_1000_2000: result=%0d lat=%0d, required 6919 lat=1", res, lat);
    end
    release_start();
  endtask

  task automatic test_unsupported_sqr();
    logic [W-1:0] res;
    logic [W-1:0] exp_sq;
    int lat;
    int exp_lat;
    do_op(3'b111, W'(123), W'(456), W'(7919), 1'b0, 0, res, lat);
    n_checks++;
    if (res !== '0 || lat != 1) begin
      n_fail++;
      $display("FAIL sel_111: result=%0h lat=%0d, required 0 lat=1", res, lat);
    end
    release_start();
`ifdef ECC_CORE_SQR_EN
    exp_sq  = W'(2081);
    exp_lat = W;
`else
    exp_sq  = '0;
    exp_lat = 1;
`endif
    do_op(3'b010, W'(100), W'(55), W'(7919), 1'b0, 0, res, lat);
    n_checks++;
    if (res !== exp_sq || lat != exp_lat) begin
      n_fail++;
      $display("FAIL sel_010: result=%0d lat=%0d, required %0d lat=%0d", res, lat, exp_sq, exp_lat);
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int lat;
    do_op(3'b000, W'(10), W'(20), W'(7919), 1'b0, 0, res, lat);
    release_start();
    start = 1'b1; alu_sel = 3'b011; a = W'(7001); b = W'(7907); prime = W'(7919);
    repeat (50) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (alu_result !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: result=%0h done=%b, required result=0 done=0", alu_result, done);
    end
    start = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    do_op(3'b011, W'(3001), W'(4001), W'(7919), 1'b0, 0, res, lat);
    n_checks++;
    if (res !== W'(16'h0705) || lat != W) begin
      n_fail++;
      $display("FAIL post_reset_mul: result=%0h lat=%0d, required 705 lat=%0d", res, lat, W);
    end
    release_start();
  endtask

  task automatic test_start_drop();
    logic [W-1:0] res;
    int lat;
    do_op(3'b011, W'(4003), W'(5009), W'(7919), 1'b0, 10, res, lat);
    n_checks++;
    if (res !== W'(16'h0077) || lat != W) begin
      n_fail++;
      $display("FAIL drop_mid_calc: result=%0h lat=%0d, required 77 lat=%0d", res, lat, W);
    end
    @(negedge i_clk);
    n_checks++;
    if (done !== 1'b0 || alu_result !== W'(16'h0077)) begin
      n_fail++;
      $display("FAIL done_one_cycle: done=%b result=%0h, required done=0 result=77", done, alu_result);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] pmax;
    logic [W-1:0] res;
    logic [W-1:0] exp_v;
    logic [2:0]   sels [3];
    int lat;
    pmax = '1;
    sels = '{3'b000, 3'b001, 3'b011};
    for (int i = 0; i < 3; i++) begin
      exp_v = model(sels[i], pmax - 1, (sels[i] == 3'b001) ? '0 : pmax - 1, pmax);
      do_op(sels[i], pmax - 1, (sels[i] == 3'b001) ? '0 : pmax - 1, pmax, 1'b0, 0, res, lat);
      n_checks++;
      if (res !== exp_v || lat != model_lat(sels[i])) begin
        n_fail++;
        $display("FAIL boundary_pmax_sel%0d: result=%0h lat=%0d, required %0h lat=%0d",
                 sels[i], res, lat, exp_v, model_lat(sels[i]));
      end
      release_start();
      exp_v = model(sels[i], W'(2), W'(2), W'(3));
      do_op(sels[i], W'(2), W'(2), W'(3), 1'b0, 0, res, lat);
      n_checks++;
      if (res !== exp_v || lat != model_lat(sels[i])) begin
        n_fail++;
        $display("FAIL boundary_p3_sel%0d: result=%0h lat=%0d, required %0h lat=%0d",
                 sels[i], res, lat, exp_v, model_lat(sels[i]));
      end
      release_start();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rp, ra, rb, res, exp_v;
    logic [2:0]   sel;
    int lat;
    for (int i = 0; i < 24; i++) begin
      rp = rand_w();
      if (rp < 3) rp = W'(3);
      ra  = rand_w() % rp;
      rb  = rand_w() % rp;
      sel = (i % 3 == 0) ? 3'b011 : 3'($urandom_range(0, 7));
      exp_v = model(sel, ra, rb, rp);
      do_op(sel, ra, rb, rp, (i % 2) == 1, 0, res, lat);
      n_checks++;
      if (res !== exp_v || lat != model_lat(sel)) begin
        n_fail++;
        $display("FAIL random_%0d sel=%0d: result=%0h lat=%0d, required %0h lat=%0d",
                 i, sel, res, lat, exp_v, model_lat(sel));
      end
      release_start();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_hold();
    test_back_to_back();
    test_add_sub();
    test_unsupported_sqr();
    test_reset_mid();
    test_start_drop();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_core.md
ECC_CORE -- requirements
Module: ecc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 256, the operand/result/modulus bit width.
REQ-002 SHALL have port i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port i_rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start  input  1  level request; operation launched on a rising edge of i_clk where start=1 in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-006 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-007 SHALL have port prime  input  WIDTH  modulus p, unsigned.
REQ-008 SHALL have port alu_sel  input  3  opcode: 000 add, 001 sub, 010 square, 011 multiply, others unsupported.
REQ-009 SHALL have port alu_result  output  WIDTH  registered result.
REQ-010 SHALL have port done  output  1  registered completion flag.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC when start=1; CALC->DONE when op finishes; DONE->IDLE when start=0.
REQ-012 SHALL capture a, b, prime, alu_sel on the IDLE->CALC edge; input changes afterwards SHALL be ignored until return to IDLE.
REQ-013 SHALL compute: 000 (a+b) mod p; 001 (a-b) mod p; 011 (a*b) mod p; 010 (a*a) mod p if enabled (REQ-023).
REQ-014 Correct results SHALL be guaranteed for 3 <= p < 2^WIDTH, a < p, b < p; out-of-range operands SHALL still yield a deterministic result in DONE, not necessarily reduced.
REQ-015 Add/sub SHALL use WIDTH+1-bit internal sums with one conditional correction (subtract p on overflow/>=p; add p on borrow); latency 1 CALC cycle.
REQ-016 Multiply SHALL be MSB-first interleaved: r=0; per cycle r = 2r + a_i*b, each step reduced by up to two conditional subtractions of p, WIDTH+2-bit intermediates; exactly WIDTH CALC cycles.
REQ-017 alu_result SHALL update and done SHALL rise on the same edge entering DONE; both SHALL hold while start=1.
REQ-018 done SHALL fall on the edge leaving DONE; alu_result SHALL hold its last value until the next launch.
REQ-019 A new operation SHALL require start to return low (DONE->IDLE) before re-launch; start held high never re-launches.
REQ-020 start dropping during CALC SHALL not abort; DONE is entered, done is high for exactly one cycle, then IDLE.
REQ-021 Unsupported alu_sel SHALL complete after 1 CALC cycle with alu_result=0 and done=1.

Reset
REQ-022 i_rst=1 SHALL immediately force IDLE, alu_result=0, done=0, clear internal registers, aborting any operation; after release the next start=1 launches normally.

Configuration
REQ-023 Macro ECC_CORE_SQR_EN defined: alu_sel 010 SHALL compute (a*a) mod p via the multiplier with WIDTH-cycle latency; undefined: 010 SHALL be treated as unsupported per REQ-021.

Verification
REQ-024 p=7919, a=1009, b=2003, sel=011, start held until done -> alu_result=0x692, done held until start=0.
REQ-025 Back-to-back multiplies p=7919, start toggled low between: (7001,7907)->0xC19, (5003,6007)->0x1A0, (4003,5009)->0x77, (1901,2503)->0x1A93; each done 256 cycles after launch.
REQ-026 p=7919, sel=000 a=5000 b=4000 -> 1081; sel=001 a=1000 b=2000 -> 6919; each done one cycle after launch.
REQ-027 Assert i_rst mid-multiply -> alu_result=0, done=0 immediately; subsequent 3001*4001 mod 7919 -> 0x705.
REQ-028 sel=111 -> alu_result=0, done=1 after one cycle; sel=010 a=100 p=7919 -> 2081 with ECC_CORE_SQR_EN, 0 without.
